// File: rtl/c3lib_rst_seq_lcell.sv
// Staggered reset release sequencer: async assert, synchronised one-at-a-time release.
// Optional build macro C3LIB_RST_SEQ_BUF_EN routes each output through a c3lib_buf_lcell.
module c3lib_rst_seq_lcell #(
    parameter int NUM_RST     = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DLY_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sw_rst_req,
    input  logic [DLY_WIDTH-1:0] dly_cfg,
    output logic [NUM_RST-1:0]   rst_out_n,
    output logic                 busy,
    output logic                 seq_done
);

    // state     | meaning
    // ST_ASSERT | all outputs held in reset, waiting for synced release and no request
    // ST_WAIT   | counting gap cycles, releasing one output per terminal count
    // ST_DONE   | every output released

    localparam int IDX_W = (NUM_RST > 1) ? $clog2(NUM_RST) : 1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_RST - 1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
    localparam logic [DLY_WIDTH-1:0] CNT_ONE  = DLY_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_ASSERT = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DLY_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DLY_WIDTH-1:0]   cfg_q, cfg_d;
    logic [NUM_RST-1:0]     rel_q, rel_d;
    logic                   synced_n;

    assign synced_n = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= ST_ASSERT;
            idx_q   <= '0;
            cnt_q   <= '0;
            cfg_q   <= '0;
            rel_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            cfg_q   <= cfg_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cfg_d   = cfg_q;
        rel_d   = rel_q;
        // A software request overrides any release scheduled for this edge.
        if (sw_rst_req) begin
            state_d = ST_ASSERT;
            idx_d   = '0;
            cnt_d   = '0;
            rel_d   = '0;
        end else begin
            case (state_q)
                ST_ASSERT: begin
                    rel_d = '0;
                    if (synced_n) begin
                        state_d = ST_WAIT;
                        cfg_d   = dly_cfg;
                        cnt_d   = dly_cfg;
                        idx_d   = '0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        rel_d[idx_q] = 1'b1;
                        cnt_d        = cfg_q;
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d = idx_q + IDX_ONE;
                        end
                    end
                end
                ST_DONE: begin
                    rel_d = '1;
                end
                default: begin
                    state_d = ST_ASSERT;
                    rel_d   = '0;
                end
            endcase
        end
    end

    assign busy     = (state_q != ST_DONE);
    assign seq_done = (state_q == ST_DONE);

`ifdef C3LIB_RST_SEQ_BUF_EN
    // One library buffer per tree keeps each reset net distinct through synthesis.
    for (genvar gi = 0; gi < NUM_RST; gi++) begin : g_rst_buf
        c3lib_buf_lcell u_rst_buf (
            .in  (rel_q[gi]),
            .out (rst_out_n[gi])
        );
    end
`else
    assign rst_out_n = rel_q;
`endif

endmodule

// File: tb/tb_c3lib_rst_seq_lcell.sv
// Directed bench for c3lib_rst_seq_lcell: per-cycle vector table plus an async reset sequence.
module tb_c3lib_rst_seq_lcell;

    logic       clk;
    logic       rst_n;
    logic       sw_rst_req;
    logic [7:0] dly_cfg;
    logic [3:0] rst_out_n;
    logic       busy;
    logic       seq_done;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst_n;
        logic       sw;
        logic [7:0] dly;
        logic [3:0] exp_out;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    c3lib_rst_seq_lcell #(
        .NUM_RST     (4),
        .SYNC_STAGES (2),
        .DLY_WIDTH   (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw_rst_req (sw_rst_req),
        .dly_cfg    (dly_cfg),
        .rst_out_n  (rst_out_n),
        .busy       (busy),
        .seq_done   (seq_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic push(input int n, input logic r, input logic s, input logic [7:0] d,
                        input logic [3:0] o, input logic b, input logic dn);
        vec_t v;
        v.rst_n = r; v.sw = s; v.dly = d; v.exp_out = o; v.exp_busy = b; v.exp_done = dn;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    task automatic check_order(input string tag);
        logic ok;
        ok = 1'b1;
        for (int k = 1; k < 4; k++)
            if (rst_out_n[k] && !rst_out_n[k-1]) ok = 1'b0;
        check({tag, "_order"}, {28'd0, rst_out_n, 3'd0, ok} >> 4, {28'd0, rst_out_n, 3'd0, 1'b1} >> 4);
        check({tag, "_order_ok"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst_n      = vecs[i].rst_n;
            sw_rst_req = vecs[i].sw;
            dly_cfg    = vecs[i].dly;
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]_out", tag, i), {28'd0, rst_out_n}, {28'd0, vecs[i].exp_out});
            check($sformatf("%s[%0d]_busy", tag, i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            check($sformatf("%s[%0d]_done", tag, i), {31'd0, seq_done}, {31'd0, vecs[i].exp_done});
            check_order($sformatf("%s[%0d]", tag, i));
        end
        vecs.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        sw_rst_req = 1'b0;
        dly_cfg    = 8'd3;

        // Power-on: gap 4 latched at exit (third edge after release); later dly_cfg=7 ignored.
        push(5, 0, 0, 8'd3, 4'b0000, 1, 0);
        push(3, 1, 0, 8'd3, 4'b0000, 1, 0);
        push(3, 1, 0, 8'd7, 4'b0000, 1, 0);
        push(4, 1, 0, 8'd7, 4'b0001, 1, 0);
        push(4, 1, 0, 8'd7, 4'b0011, 1, 0);
        push(4, 1, 0, 8'd7, 4'b0111, 1, 0);
        push(3, 1, 0, 8'd7, 4'b1111, 0, 1);
        // Software re-reset from DONE; restart picks up dly_cfg=7 -> gap 8.
        push(3, 1, 1, 8'd7, 4'b0000, 1, 0);
        push(8, 1, 0, 8'd7, 4'b0000, 1, 0);
        push(8, 1, 0, 8'd7, 4'b0001, 1, 0);
        push(8, 1, 0, 8'd7, 4'b0011, 1, 0);
        push(8, 1, 0, 8'd7, 4'b0111, 1, 0);
        push(2, 1, 0, 8'd7, 4'b1111, 0, 1);
        // Back to gap 4.
        push(3, 1, 1, 8'd3, 4'b0000, 1, 0);
        push(4, 1, 0, 8'd3, 4'b0000, 1, 0);
        push(4, 1, 0, 8'd3, 4'b0001, 1, 0);
        push(4, 1, 0, 8'd3, 4'b0011, 1, 0);
        push(4, 1, 0, 8'd3, 4'b0111, 1, 0);
        push(2, 1, 0, 8'd3, 4'b1111, 0, 1);
        // dly_cfg=0: one release per cycle, done 4 edges after exit.
        push(2, 1, 1, 8'd0, 4'b0000, 1, 0);
        push(1, 1, 0, 8'd0, 4'b0000, 1, 0);
        push(1, 1, 0, 8'd0, 4'b0001, 1, 0);
        push(1, 1, 0, 8'd0, 4'b0011, 1, 0);
        push(1, 1, 0, 8'd0, 4'b0111, 1, 0);
        push(2, 1, 0, 8'd0, 4'b1111, 0, 1);
        // Request coincides with the release of bit 2: request wins.
        push(1, 1, 1, 8'd0, 4'b0000, 1, 0);
        push(1, 1, 0, 8'd0, 4'b0000, 1, 0);
        push(1, 1, 0, 8'd0, 4'b0001, 1, 0);
        push(1, 1, 0, 8'd0, 4'b0011, 1, 0);
        push(1, 1, 1, 8'd0, 4'b0000, 1, 0);
        push(1, 1, 0, 8'd0, 4'b0000, 1, 0);
        push(1, 1, 0, 8'd0, 4'b0001, 1, 0);
        push(1, 1, 0, 8'd0, 4'b0011, 1, 0);
        push(1, 1, 0, 8'd0, 4'b0111, 1, 0);
        push(2, 1, 0, 8'd0, 4'b1111, 0, 1);
        run_vecs("tbl");

        // Async rst_n assertion mid-sequence, observed before any clock edge.
        @(negedge clk);
        sw_rst_req = 1'b1;
        dly_cfg    = 8'd3;
        @(negedge clk);
        sw_rst_req = 1'b0;
        @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
        check("mid_pre_out", {28'd0, rst_out_n}, 32'h3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out", {28'd0, rst_out_n}, 32'h0);
        check("async_busy", {31'd0, busy}, 32'd1);
        check("async_done", {31'd0, seq_done}, 32'd0);

        // Release again: sync chain was cleared too, so exit is back on the third edge.
        push(6, 1, 0, 8'd3, 4'b0000, 1, 0);
        push(4, 1, 0, 8'd3, 4'b0001, 1, 0);
        push(4, 1, 0, 8'd3, 4'b0011, 1, 0);
        push(4, 1, 0, 8'd3, 4'b0111, 1, 0);
        push(2, 1, 0, 8'd3, 4'b1111, 0, 1);
        run_vecs("rel");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
